mux_n_wrr: RTL

MUX_N_WRR -- requirements
Module: mux_n_wrr

---
 rtl/mux_n_wrr_pkg.sv | 23 ++
 rtl/fallthrough_small_fifo.sv | 75 +++++++
 rtl/mux_n_wrr.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mux_n_wrr_pkg.sv
// Shared definitions for the weighted round-robin / strict-priority AXI-Stream mux.
package mux_n_wrr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    WR_PKT = 1'b1
  } state_e;

  // Ceiling log2, evaluated at elaboration time for widths and depths.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout while not empty.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE      = MAX_DEPTH_BITS'(1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE      = (MAX_DEPTH_BITS + 1)'(1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL     = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_NEARLY   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                      wr_fire;
  logic                      rd_fire;

  assign empty       = (cnt_q == '0);
  assign nearly_full = (cnt_q >= CNT_NEARLY);
  assign wr_fire     = wr_en && (cnt_q != CNT_FULL);
  assign rd_fire     = rd_en && !empty;
  assign dout        = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_fire, rd_fire})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mux_n_wrr.sv
// N-queue AXI-Stream packet mux: per-queue FIFOs, atomic packet forwarding,
// weighted round-robin or strict-priority queue selection.
module mux_n_wrr
  import mux_n_wrr_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 4,
  parameter int QUEUE_WEIGHT       = 1,
  parameter int MAX_PKT_SIZE       = 2048
) (
  input  logic                                          axis_aclk,
  input  logic                                          axis_resetn,
  input  logic                                          prio_mode,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [NUM_QUEUES*(C_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tkeep,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                         s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  output logic [log2(NUM_QUEUES)-1:0]                   grant_q,
  output logic                                          busy,
  output logic [31:0]                                   pkt_cnt
);

  localparam int DW         = C_AXIS_DATA_WIDTH;
  localparam int KW         = C_AXIS_DATA_WIDTH / 8;
  localparam int UW         = C_AXIS_TUSER_WIDTH;
  localparam int FIFO_W     = DW + UW + KW + 1;
  localparam int DEPTH_BITS = log2(MAX_PKT_SIZE / KW);
  localparam int QW         = log2(NUM_QUEUES);
  localparam logic [7:0]    CREDIT_RELOAD = 8'(QUEUE_WEIGHT - 1);
  localparam logic [7:0]    CREDIT_ONE    = 8'd1;

  state_e                  state_q, state_d;
  logic [QW-1:0]           grant_d;
  logic [7:0]              credit_q, credit_d;
  logic [31:0]             pkt_cnt_q, pkt_cnt_d;
  logic [NUM_QUEUES-1:0]   fifo_empty;
  logic [NUM_QUEUES-1:0]   fifo_nearly_full;
  logic [NUM_QUEUES-1:0]   fifo_wr_en;
  logic [NUM_QUEUES-1:0]   fifo_rd_en;
  logic [FIFO_W-1:0]       fifo_dout [NUM_QUEUES];
  logic [FIFO_W-1:0]       head;
  logic [QW-1:0]           rr_sel;
  logic [QW-1:0]           prio_sel;
  logic                    rr_found;
  int                      rr_idx;

  assign s_axis_tready = ~fifo_nearly_full & {NUM_QUEUES{axis_resetn}};
  assign fifo_wr_en    = s_axis_tvalid & s_axis_tready;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
    fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
      .clk         (axis_aclk),
      .rst_n       (axis_resetn),
      .din         ({s_axis_tdata[i*DW +: DW], s_axis_tuser[i*UW +: UW],
                     s_axis_tkeep[i*KW +: KW], s_axis_tlast[i]}),
      .wr_en       (fifo_wr_en[i]),
      .rd_en       (fifo_rd_en[i]),
      .dout        (fifo_dout[i]),
      .nearly_full (fifo_nearly_full[i]),
      .empty       (fifo_empty[i])
    );
  end

  assign head = fifo_dout[grant_q];
  assign {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast} = head;
  assign m_axis_tvalid = (state_q == WR_PKT) && !fifo_empty[grant_q];
  assign busy          = (state_q == WR_PKT);
  assign pkt_cnt       = pkt_cnt_q;

  // Round-robin scans from the queue after the current grant, ending on it;
  // priority takes the lowest-index non-empty queue.
  always_comb begin
    rr_sel   = grant_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      rr_idx = int'(grant_q) + i;
      if (rr_idx >= NUM_QUEUES) begin
        rr_idx = rr_idx - NUM_QUEUES;
      end else begin
        rr_idx = rr_idx;
      end
      if (!rr_found && !fifo_empty[rr_idx]) begin
        rr_sel   = QW'(rr_idx);
        rr_found = 1'b1;
      end else begin
        rr_found = rr_found;
      end
    end
    prio_sel = grant_q;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (!fifo_empty[i]) begin
        prio_sel = QW'(i);
      end else begin
        prio_sel = prio_sel;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    credit_d   = credit_q;
    pkt_cnt_d  = pkt_cnt_q;
    fifo_rd_en = '0;
    case (state_q)
      IDLE: begin
        if (fifo_empty != {NUM_QUEUES{1'b1}}) begin
          state_d = WR_PKT;
          if (prio_mode) begin
            grant_d  = prio_sel;
            credit_d = 8'd0;
          end else if ((credit_q != 8'd0) && !fifo_empty[grant_q]) begin
            credit_d = credit_q - CREDIT_ONE;
          end else begin
            grant_d  = rr_sel;
            credit_d = CREDIT_RELOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_PKT: begin
        if (!fifo_empty[grant_q] && m_axis_tready) begin
          fifo_rd_en[grant_q] = 1'b1;
          if (m_axis_tlast) begin
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            state_d = WR_PKT;
          end
        end else begin
          state_d = WR_PKT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset parks the grant on the last queue so the first scan starts at queue 0.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= IDLE;
      grant_q   <= QW'(NUM_QUEUES - 1);
      credit_q  <= 8'd0;
      pkt_cnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      credit_q  <= credit_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule
